// File: rtl/upg_pkg.sv
// -----------------------------------------------------------------------------
// upg_pkg
// Shared types and constants for the UART programmer (upg_loader).
//   - upg_state_e : loader FSM states (ST_CKSUM only when UPG_CHECKSUM_EN)
//   - rx_state_e  : UART receiver sampler states
//   - UPG_SEC_*   : section select bit placed in upg_adr_o[14]
//   - UPG_ADR_W / UPG_DAT_W : write-bus widths
//   - is_busy()   : true while a load session is in progress
// Optional feature macro: UPG_CHECKSUM_EN (adds the trailing checksum state).
// -----------------------------------------------------------------------------
package upg_pkg;

  localparam int UPG_ADR_W = 15;
  localparam int UPG_DAT_W = 32;

  localparam logic UPG_SEC_INST = 1'b0;
  localparam logic UPG_SEC_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ICNT0,
    ST_ICNT1,
    ST_IWORD,
    ST_DCNT0,
    ST_DCNT1,
    ST_DWORD,
`ifdef UPG_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE,
    ST_ERR
  } upg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // A session is "in progress" in every state except the three resting ones.
  function automatic logic is_busy(input upg_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR));
  endfunction

endpackage

// File: rtl/upg_uart_rx.sv
// -----------------------------------------------------------------------------
// upg_uart_rx
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit
// sampling, LSB first.
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-low reset
//   rx         in   serial input, idle high
//   byte_valid out  one-cycle pulse, good byte received
//   byte_data  out  received byte (valid with byte_valid)
//   ferr       out  one-cycle pulse, stop bit sampled low (byte dropped)
// -----------------------------------------------------------------------------
module upg_uart_rx
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 78
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // Synchroniser and edge-detect flops reset high so an idle line never looks
  // like a start edge coming out of reset.
  logic           rx_meta_reg;
  logic           rx_sync_reg;
  logic           rx_prev_reg;
  rx_state_e      state_reg;
  logic [CW-1:0]  clk_cnt_reg;
  logic [2:0]     bit_idx_reg;
  logic [7:0]     shift_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= RX_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      ferr        <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      byte_valid  <= 1'b0;
      ferr        <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            state_reg   <= RX_START;
            clk_cnt_reg <= '0;
          end
        end
        RX_START: begin
          // Half a bit in: a high line means the edge was a glitch.
          if (clk_cnt_reg == HALF_LAST) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) state_reg <= RX_STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop leaves the rest of the stop bit
          // for catching the next start edge.
          if (clk_cnt_reg == BIT_LAST) begin
            clk_cnt_reg <= '0;
            state_reg   <= RX_IDLE;
            if (rx_sync_reg) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/upg_loader.sv
// -----------------------------------------------------------------------------
// upg_loader
// UART programmer front end. Receives count/word stream for the instruction
// and data sections and drives the upg_* write bus; upg_done_o releases the
// CPU from programming mode.
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   upg_start_i  in   rising edge starts a new session (from IDLE/DONE/ERR)
//   rx_i         in   UART serial input, idle high, 8N1
//   upg_wen_o    out  one-cycle write strobe
//   upg_adr_o    out  [14] section (0 inst ROM, 1 data RAM), [13:0] word
//   upg_dat_o    out  write data (held until next strobe)
//   upg_done_o   out  session complete, sticky
//   upg_err_o    out  protocol/framing error, sticky
//   busy_o       out  session in progress
// Optional feature macro: UPG_CHECKSUM_EN (trailing 8-bit sum byte).
// -----------------------------------------------------------------------------
module upg_loader
  import upg_pkg::*;
#(
  parameter int CLK_HZ         = 10000000,
  parameter int BAUD           = 128000,
  parameter int INST_WORDS_MAX = 16384,
  parameter int DATA_WORDS_MAX = 16384
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 upg_start_i,
  input  logic                 rx_i,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [UPG_DAT_W-1:0] upg_dat_o,
  output logic                 upg_done_o,
  output logic                 upg_err_o,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  upg_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx_i),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .ferr       (rx_ferr)
  );

  upg_state_e  state_reg;
  logic        start_d_reg;
  logic [7:0]  cnt_lo_reg;
  logic [15:0] cnt_reg;
  logic [14:0] word_idx_reg;   // one bit wider than the address so it can reach 16384
  logic [1:0]  byte_idx_reg;
  logic [23:0] word_buf_reg;   // lanes 0..2; lane 3 goes straight to upg_dat_o
`ifdef UPG_CHECKSUM_EN
  logic [7:0]  sum_reg;
`endif

  logic        start_rise;
  logic [15:0] cnt_word;
  logic        last_word;
  logic        sec_bit;

  assign start_rise = upg_start_i & ~start_d_reg;
  assign cnt_word   = {rx_byte, cnt_lo_reg};
  assign last_word  = (({1'b0, word_idx_reg}) + 16'd1) == cnt_reg;
  assign sec_bit    = (state_reg == ST_DWORD) ? UPG_SEC_DATA : UPG_SEC_INST;
  assign busy_o     = is_busy(state_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      start_d_reg  <= 1'b0;
      cnt_lo_reg   <= '0;
      cnt_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      word_buf_reg <= '0;
`ifdef UPG_CHECKSUM_EN
      sum_reg      <= '0;
`endif
      upg_wen_o    <= 1'b0;
      upg_adr_o    <= '0;
      upg_dat_o    <= '0;
      upg_done_o   <= 1'b0;
      upg_err_o    <= 1'b0;
    end else begin
      start_d_reg <= upg_start_i;
      upg_wen_o   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      if (rx_valid && is_busy(state_reg)) sum_reg <= sum_reg + rx_byte;
`endif
      if (rx_ferr && is_busy(state_reg)) begin
        state_reg <= ST_ERR;
        upg_err_o <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_rise) begin
              state_reg    <= ST_ICNT0;
              upg_done_o   <= 1'b0;
              upg_err_o    <= 1'b0;
              cnt_reg      <= '0;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
`ifdef UPG_CHECKSUM_EN
              sum_reg      <= '0;
`endif
            end
          end
          ST_ICNT0, ST_DCNT0: begin
            if (rx_valid) begin
              cnt_lo_reg <= rx_byte;
              state_reg  <= (state_reg == ST_ICNT0) ? ST_ICNT1 : ST_DCNT1;
            end
          end
          ST_ICNT1: begin
            if (rx_valid) begin
              cnt_reg      <= cnt_word;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
              if (32'(cnt_word) > 32'(INST_WORDS_MAX)) begin
                state_reg <= ST_ERR;
                upg_err_o <= 1'b1;
              end else if (cnt_word == 16'd0) begin
                state_reg <= ST_DCNT0;
              end else begin
                state_reg <= ST_IWORD;
              end
            end
          end
          ST_DCNT1: begin
            if (rx_valid) begin
              cnt_reg      <= cnt_word;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
              if (32'(cnt_word) > 32'(DATA_WORDS_MAX)) begin
                state_reg <= ST_ERR;
                upg_err_o <= 1'b1;
              end else if (cnt_word == 16'd0) begin
`ifdef UPG_CHECKSUM_EN
                state_reg  <= ST_CKSUM;
`else
                state_reg  <= ST_DONE;
                upg_done_o <= 1'b1;
`endif
              end else begin
                state_reg <= ST_DWORD;
              end
            end
          end
          ST_IWORD, ST_DWORD: begin
            // The strobe cycle does the bookkeeping, so done/next-section
            // appears one cycle after the last strobe.
            if (upg_wen_o) begin
              word_idx_reg <= word_idx_reg + 15'd1;
              if (last_word) begin
                if (state_reg == ST_IWORD) begin
                  state_reg <= ST_DCNT0;
                end else begin
`ifdef UPG_CHECKSUM_EN
                  state_reg  <= ST_CKSUM;
`else
                  state_reg  <= ST_DONE;
                  upg_done_o <= 1'b1;
`endif
                end
              end
            end else if (rx_valid) begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
              if (byte_idx_reg == 2'd3) begin
                upg_wen_o <= 1'b1;
                upg_adr_o <= {sec_bit, word_idx_reg[13:0]};
                upg_dat_o <= {rx_byte, word_buf_reg};
              end else begin
                word_buf_reg[{byte_idx_reg, 3'b000} +: 8] <= rx_byte;
              end
            end
          end
`ifdef UPG_CHECKSUM_EN
          ST_CKSUM: begin
            if (rx_valid) begin
              if (rx_byte == sum_reg) begin
                state_reg  <= ST_DONE;
                upg_done_o <= 1'b1;
              end else begin
                state_reg <= ST_ERR;
                upg_err_o <= 1'b1;
              end
            end
          end
`endif
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upg_loader.sv
// -----------------------------------------------------------------------------
// tb_upg_loader
// Directed bench for upg_loader: a table of byte streams with expected
// strobes/status, plus hand sequences for framing error, mid-word reset and
// (when UPG_CHECKSUM_EN is defined) a bad checksum.
// -----------------------------------------------------------------------------
module tb_upg_loader;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UPG_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        upg_start_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;
  logic        busy_o;

  always #5 clock = ~clock;

  upg_loader #(
    .CLK_HZ         (CLK_HZ),
    .BAUD           (BAUD),
    .INST_WORDS_MAX (16384),
    .DATA_WORDS_MAX (16384)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .upg_start_i (upg_start_i),
    .rx_i        (rx_i),
    .upg_wen_o   (upg_wen_o),
    .upg_adr_o   (upg_adr_o),
    .upg_dat_o   (upg_dat_o),
    .upg_done_o  (upg_done_o),
    .upg_err_o   (upg_err_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Strobe log, filled on the falling edge.
  logic [14:0] log_adr [0:255];
  logic [31:0] log_dat [0:255];
  int          n_strobe = 0;

  always @(negedge clock) begin
    if (upg_wen_o) begin
      if (n_strobe < 256) begin
        log_adr[n_strobe] <= upg_adr_o;
        log_dat[n_strobe] <= upg_dat_o;
      end
      n_strobe <= n_strobe + 1;
    end
  end

  typedef struct {
    logic [127:0] s;    // stream, first byte in the most significant used byte
    int           n;
    int           ns;
    logic [14:0]  a0;
    logic [31:0]  d0;
    logic [14:0]  a1;
    logic [31:0]  d1;
    bit           done;
    bit           err;
  } vec_t;

  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = ~bad_stop;
    tick(CPB);
    rx_i = 1'b1;
    tick(4);
  endtask

  // Sends n bytes; start is dropped after the second byte to show only its
  // rising edge matters. Appends sum+ck_delta when the checksum is built in.
  task automatic send_stream(input logic [127:0] s, input int n, input bit with_ck,
                             input logic [7:0] ck_delta);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b   = s[8*(n-1-i) +: 8];
      sum = sum + b;
      send_byte(b, 1'b0);
      if (i == 1) upg_start_i = 1'b0;
    end
    if (CK_EN && with_ck) send_byte(sum + ck_delta, 1'b0);
    tick(6);
  endtask

  task automatic start_session();
    upg_start_i = 1'b0;
    tick(3);
    upg_start_i = 1'b1;
    tick(3);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_done_clr", 32'(upg_done_o), 32'd0);
    chk("start_err_clr", 32'(upg_err_o), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wen"}, 32'(upg_wen_o), 32'd0);
    chk({tag, "_adr"}, 32'(upg_adr_o), 32'd0);
    chk({tag, "_dat"}, upg_dat_o, 32'd0);
    chk({tag, "_done"}, 32'(upg_done_o), 32'd0);
    chk({tag, "_err"}, 32'(upg_err_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int base;

    vecs[0] = '{s: 128'h0100785634120000, n: 8, ns: 1,
                a0: 15'h0000, d0: 32'h12345678, a1: 15'h0, d1: 32'h0, done: 1, err: 0};
    vecs[1] = '{s: 128'h00000200EFBEADDE01000000, n: 12, ns: 2,
                a0: 15'h4000, d0: 32'hDEADBEEF, a1: 15'h4001, d1: 32'h00000001, done: 1, err: 0};
    vecs[2] = '{s: 128'h0050, n: 2, ns: 0,
                a0: 15'h0, d0: 32'h0, a1: 15'h0, d1: 32'h0, done: 0, err: 1};
    vecs[3] = '{s: 128'h00000000, n: 4, ns: 0,
                a0: 15'h0, d0: 32'h0, a1: 15'h0, d1: 32'h0, done: 1, err: 0};
    vecs[4] = '{s: 128'h0100AABBCCDD010011223344, n: 12, ns: 2,
                a0: 15'h0000, d0: 32'hDDCCBBAA, a1: 15'h4000, d1: 32'h44332211, done: 1, err: 0};
    vecs[5] = '{s: 128'h00000140, n: 4, ns: 0,
                a0: 15'h0, d0: 32'h0, a1: 15'h0, d1: 32'h0, done: 0, err: 1};
    vecs[6] = '{s: 128'h0100040302010000, n: 8, ns: 1,
                a0: 15'h0000, d0: 32'h01020304, a1: 15'h0, d1: 32'h0, done: 1, err: 0};

    // Reset state
    reset = 1'b0;
    tick(3);
    chk_idle_outputs("reset");
    reset = 1'b1;
    tick(3);

    // Table-driven streams
    for (int v = 0; v < 7; v++) begin
      base = n_strobe;
      start_session();
      send_stream(vecs[v].s, vecs[v].n, !vecs[v].err, 8'h00);
      chk($sformatf("v%0d_nstrobe", v), 32'(n_strobe - base), 32'(vecs[v].ns));
      for (int k = 0; k < vecs[v].ns; k++) begin
        chk($sformatf("v%0d_adr%0d", v, k), 32'(log_adr[base+k]),
            32'((k == 0) ? vecs[v].a0 : vecs[v].a1));
        chk($sformatf("v%0d_dat%0d", v, k), log_dat[base+k],
            (k == 0) ? vecs[v].d0 : vecs[v].d1);
      end
      chk($sformatf("v%0d_done", v), 32'(upg_done_o), 32'(vecs[v].done));
      chk($sformatf("v%0d_err", v), 32'(upg_err_o), 32'(vecs[v].err));
      chk($sformatf("v%0d_busy", v), 32'(busy_o), 32'd0);
      $display("vec %0d: strobes=%0d done=%0b err=%0b busy=%0b",
               v, n_strobe - base, upg_done_o, upg_err_o, busy_o);
    end

    // Framing error mid-IWORD, then recovery with a fresh session
    base = n_strobe;
    start_session();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    tick(6);
    chk("ferr_err", 32'(upg_err_o), 32'd1);
    chk("ferr_done", 32'(upg_done_o), 32'd0);
    chk("ferr_busy", 32'(busy_o), 32'd0);
    chk("ferr_nstrobe", 32'(n_strobe - base), 32'd0);
    $display("ferr: strobes=%0d done=%0b err=%0b", n_strobe - base, upg_done_o, upg_err_o);
    base = n_strobe;
    start_session();
    send_stream(vecs[0].s, vecs[0].n, 1'b1, 8'h00);
    chk("recov_done", 32'(upg_done_o), 32'd1);
    chk("recov_err", 32'(upg_err_o), 32'd0);
    chk("recov_nstrobe", 32'(n_strobe - base), 32'd1);
    chk("recov_dat", log_dat[base], 32'h12345678);
    $display("recover: strobes=%0d done=%0b err=%0b", n_strobe - base, upg_done_o, upg_err_o);

    // Reset mid-word: one complete word, then two bytes of the second
    base = n_strobe;
    start_session();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    upg_start_i = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    chk("pre_rst_nstrobe", 32'(n_strobe - base), 32'd1);
    chk("pre_rst_dat", log_dat[base], 32'h04030201);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    reset = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    tick(4);
    chk("midrst_nstrobe", 32'(n_strobe - base), 32'd1);
    reset = 1'b1;
    tick(3);
    base = n_strobe;
    start_session();
    send_stream(vecs[0].s, vecs[0].n, 1'b1, 8'h00);
    chk("post_rst_nstrobe", 32'(n_strobe - base), 32'd1);
    chk("post_rst_adr", 32'(log_adr[base]), 32'h0000);
    chk("post_rst_dat", log_dat[base], 32'h12345678);
    chk("post_rst_done", 32'(upg_done_o), 32'd1);
    $display("midreset: strobes=%0d adr=%h done=%0b", n_strobe - base, upg_adr_o, upg_done_o);

`ifdef UPG_CHECKSUM_EN
    // Same stream as vecs[6] with a checksum one too high (0x0C)
    base = n_strobe;
    start_session();
    send_stream(vecs[6].s, vecs[6].n, 1'b1, 8'h01);
    chk("badck_err", 32'(upg_err_o), 32'd1);
    chk("badck_done", 32'(upg_done_o), 32'd0);
    chk("badck_nstrobe", 32'(n_strobe - base), 32'd1);
    chk("badck_dat", log_dat[base], 32'h01020304);
    $display("badcksum: strobes=%0d done=%0b err=%0b", n_strobe - base, upg_done_o, upg_err_o);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
